memory_stage: RTL

Pipeline stage directly downstream of the execute stage. Latches the execute result from the EX/MEM boundary and performs RV32I loads and stores against a handshaked data-memory port. Stalls upstream while an access is in flight. Delivers the writeback value (load data or ALU result) to the writeback stage, and provides the ALU result forwarding value back to execute.

---
 rtl/memory_stage.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : memory_stage
// Purpose  : RV32I memory pipeline stage. Latches the execute result, performs
//            loads/stores over a req/gnt/rvalid data-memory port, stalls
//            upstream while an access is in flight, and delivers the writeback
//            value plus the ALU forwarding value.
// Ports    : clk, reset (sync, active-high)
//            in_*        : execute-stage result and control
//            stall       : upstream hold, high whenever an access is in flight
//            alu_result_memory : latched ALU result for execute forwarding
//            dmem_*      : data-memory request/response channel
//            out_*       : registered writeback fields, out_valid pulses once
//                          per completed instruction
// Options  : MEMORY_STAGE_MISALIGN_TRAP_EN adds out_misaligned; misaligned
//            loads/stores then complete immediately without a memory access.
//            When undefined, unused low address bits are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module memory_stage #(
  parameter int XLEN     = 32,
  parameter int ADDR_LSB = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_write,
  output logic              stall,
  output logic [XLEN-1:0]   alu_result_memory,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN/8-1:0] dmem_wstrb,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_result,
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
  output logic              out_misaligned,
`endif
  output logic [4:0]        out_rd,
  output logic              out_reg_write
);

  localparam int c_STRB_W = XLEN / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Latched execute result
  logic              r_mem_read;
  logic              r_mem_write;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_alu_result;
  logic [XLEN-1:0]   r_store_data;
  logic [4:0]        r_rd;
  logic              r_reg_write;

  // Registered writeback outputs
  logic              r_out_valid;
  logic [XLEN-1:0]   r_out_result;
  logic [4:0]        r_out_rd;
  logic              r_out_reg_write;

  logic              w_accept;
  logic              w_is_mem;
  logic              w_misaligned;
  logic              w_in_req;
  logic [c_STRB_W-1:0] w_wstrb;
  logic [XLEN-1:0]   w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_load_value;

  assign w_is_mem = in_mem_read | in_mem_write;
  assign w_accept = in_valid && (r_state == ST_IDLE);

`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
  logic r_out_misaligned;

  // Size comes from funct3[1:0]: 00 byte, 01 half, 1x word (incl. reserved).
  always_comb begin
    w_misaligned = 1'b0;
    if (w_is_mem) begin
      if (in_funct3[1])
        w_misaligned = |in_alu_result[1:0];
      else if (in_funct3[0])
        w_misaligned = in_alu_result[0];
    end
  end

  assign out_misaligned = r_out_misaligned;
`else
  assign w_misaligned = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    stall        = 1'b0;
    w_in_req     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_mem && !w_misaligned)
          w_next_state = ST_REQ;
      end
      ST_REQ: begin
        stall    = 1'b1;
        w_in_req = 1'b1;
        if (dmem_gnt)
          w_next_state = r_mem_read ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (dmem_rvalid)
          w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request channel: everything is zero outside REQ so the port is quiet at
  // reset and between accesses.
  // --------------------------------------------------------------------------
  always_comb begin
    w_wstrb = '0;
    w_wdata = '0;
    if (w_in_req) begin
      case (r_funct3[1:0])
        2'b00: begin
          w_wstrb = 4'b0001 << r_alu_result[1:0];
          w_wdata = {4{r_store_data[7:0]}};
        end
        2'b01: begin
          w_wstrb = 4'b0011 << {r_alu_result[1], 1'b0};
          w_wdata = {2{r_store_data[15:0]}};
        end
        default: begin
          w_wstrb = 4'b1111;
          w_wdata = r_store_data;
        end
      endcase
    end
  end

  assign dmem_req   = w_in_req;
  assign dmem_we    = w_in_req & r_mem_write;
  assign dmem_addr  = w_in_req ? {r_alu_result[XLEN-1:ADDR_LSB], {ADDR_LSB{1'b0}}} : '0;
  assign dmem_wdata = w_wdata;
  assign dmem_wstrb = w_wstrb;

  // --------------------------------------------------------------------------
  // Load lane extraction and extension
  // --------------------------------------------------------------------------
  always_comb begin
    case (r_alu_result[1:0])
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_value = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_load_value = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100:  w_load_value = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_load_value = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_value = dmem_rdata;
    endcase
  end

  // --------------------------------------------------------------------------
  // Input latch and writeback registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_funct3        <= '0;
      r_alu_result    <= '0;
      r_store_data    <= '0;
      r_rd            <= '0;
      r_reg_write     <= 1'b0;
      r_out_valid     <= 1'b0;
      r_out_result    <= '0;
      r_out_rd        <= '0;
      r_out_reg_write <= 1'b0;
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
      r_out_misaligned <= 1'b0;
`endif
    end else begin
      r_out_valid <= 1'b0;
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
      r_out_misaligned <= 1'b0;
`endif
      if (w_accept) begin
        r_mem_read   <= in_mem_read;
        r_mem_write  <= in_mem_write;
        r_funct3     <= in_funct3;
        r_alu_result <= in_alu_result;
        r_store_data <= in_store_data;
        r_rd         <= in_rd;
        r_reg_write  <= in_reg_write;
        if (!w_is_mem) begin
          // ALU-only instruction completes one cycle after accept.
          r_out_valid     <= 1'b1;
          r_out_result    <= in_alu_result;
          r_out_rd        <= in_rd;
          r_out_reg_write <= in_reg_write;
        end else if (w_misaligned) begin
          // Trap completion reports the faulting address, never writes rd.
          r_out_valid     <= 1'b1;
          r_out_result    <= in_alu_result;
          r_out_rd        <= in_rd;
          r_out_reg_write <= 1'b0;
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
          r_out_misaligned <= 1'b1;
`endif
        end
      end
      if ((r_state == ST_REQ) && dmem_gnt && !r_mem_read) begin
        r_out_valid     <= 1'b1;
        r_out_result    <= r_alu_result;
        r_out_rd        <= r_rd;
        r_out_reg_write <= 1'b0;
      end
      if ((r_state == ST_WAIT) && dmem_rvalid) begin
        r_out_valid     <= 1'b1;
        r_out_result    <= w_load_value;
        r_out_rd        <= r_rd;
        r_out_reg_write <= r_reg_write;
      end
    end
  end

  assign alu_result_memory = r_alu_result;
  assign out_valid         = r_out_valid;
  assign out_result        = r_out_result;
  assign out_rd            = r_out_rd;
  assign out_reg_write     = r_out_reg_write;

endmodule
`default_nettype wire
